rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 iss_valid  input  1  issue stage announces an instruction that will write iss_rd.
REQ-006 iss_rd  input  ADDR_WIDTH  destination register of issuing instruction.
REQ-007 iss_ready  output  1  issue accepted this cycle.
REQ-008 chk_raddr1, chk_raddr2  input  ADDR_WIDTH  source registers to check for hazards.
REQ-009 chk_busy  output  1  either source register has a pending write.
REQ-010 wb0_valid, wb1_valid  input  1  EXU (0) and LSU (1) writeback requests.
REQ-011 wb0_waddr, wb1_waddr  input  ADDR_WIDTH  writeback destination per requester.
REQ-012 wb0_wdata, wb1_wdata  input  DATA_WIDTH  writeback data per requester.
REQ-013 wb0_ready, wb1_ready  output  1  grant; request consumed when valid & ready.
REQ-014 rf_wen  output  1  register-file write enable.
REQ-015 rf_waddr  output  ADDR_WIDTH  register-file write address.
REQ-016 rf_wdata  output  DATA_WIDTH  register-file write data.

Function
REQ-017 Scoreboard: one pending bit per register index 1..2**ADDR_WIDTH-1; index 0 never pending.
REQ-018 iss_ready = ~pending[iss_rd] (combinational); iss_rd==0 always ready, sets nothing.
REQ-019 iss_valid & iss_ready with iss_rd!=0 sets pending[iss_rd] at next edge.
REQ-020 chk_busy = pending[chk_raddr1] | pending[chk_raddr2], combinational; index 0 contributes 0.
REQ-021 Arbiter: at most one grant per cycle; wbN_ready depends only on both valids and pointer state.
REQ-022 Pointer states PRI0, PRI1; reset PRI0; PRIk means requester k wins a conflict.
REQ-023 Single valid requester is granted regardless of pointer.
REQ-024 After any grant to requester k, pointer moves to state favouring the other requester; no grant leaves pointer unchanged.
REQ-025 Write latency 1: grant in cycle N -> rf_wen/rf_waddr/rf_wdata registered, visible cycle N+1 for exactly one cycle.
REQ-026 Granted request with waddr==0: consumed, rf_wen stays 0, no scoreboard change.
REQ-027 rf_wen=1 in cycle N+1 clears pending[rf_waddr] at end of cycle N+1.
REQ-028 Same-edge set and clear of same index: set wins (bit stays 1).
REQ-029 When rf_wen=0, rf_waddr and rf_wdata hold previous values.
REQ-030 Writeback to a non-pending register is legal; write performed, scoreboard unchanged.

Reset
REQ-031 rst=0 asynchronously forces: all pending bits 0, pointer PRI0, rf_wen 0, rf_waddr 0, rf_wdata 0.
REQ-032 Reset mid-operation discards any granted-but-unwritten request; no rf_wen pulse after release.
REQ-033 During reset iss_ready=1, chk_busy=0; wbN_ready follow REQ-021..023 and are ignored.

Structure
REQ-034 Shared package holds ADDR_WIDTH/DATA_WIDTH defaults and pointer state enum (PRI0, PRI1).
REQ-035 Two-requester round-robin logic is a sub-module rr_arb2 (req[1:0], gnt[1:0], clk, rst).
REQ-036 Scoreboard and write-output register live in rf_wb_arbiter.

Verification
REQ-037 Issue rd=5, then chk_raddr1=5 -> chk_busy=1; wb0 writes 5, data 0xDEADBEEF -> rf_wen=1 next cycle, chk_busy=0 one cycle later.
REQ-038 wb0 and wb1 valid three consecutive cycles from reset -> grants 0,1,0; rf_waddr sequence matches one cycle later.
REQ-039 Issue rd=7 twice consecutively -> second cycle iss_ready=0 until writeback to 7 commits.
REQ-040 wb1 request waddr=0, data 0x1234 -> wb1_ready=1, rf_wen stays 0 all cycles.
REQ-041 Same cycle issue rd=9 and rf_wen commit to 9 -> pending[9]=1 afterwards (chk_busy=1 on raddr 9).
REQ-042 Assert rst=0 in cycle after a grant -> rf_wen=0 immediately, no write after release, all chk_busy=0, next conflict grants requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths
// and the round-robin pointer encoding.
package rf_wb_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  // PRIk means requester k wins when both request in the same cycle.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } ptr_state_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; grants depend only on req and the pointer,
// and the pointer flips to favour the loser after every grant.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  ptr_state_e ptr_q;
  ptr_state_e ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (req[0] && (!req[1] || ptr_q == PRI0)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
    if (gnt[0]) begin
      ptr_d = PRI1;
    end else if (gnt[1]) begin
      ptr_d = PRI0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PRI0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pending-write scoreboard for issue/hazard
// checks plus a registered, round-robin arbitrated write port for EXU and LSU.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] chk_raddr1,
  input  logic [ADDR_WIDTH-1:0] chk_raddr2,
  output logic                  chk_busy,
  input  logic                  wb0_valid,
  input  logic [ADDR_WIDTH-1:0] wb0_waddr,
  input  logic [DATA_WIDTH-1:0] wb0_wdata,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [ADDR_WIDTH-1:0] wb1_waddr,
  input  logic [DATA_WIDTH-1:0] wb1_wdata,
  output logic                  wb1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       pending_q;
  logic [NREG-1:0]       pending_d;
  logic                  rf_wen_q;
  logic                  rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [DATA_WIDTH-1:0] rf_wdata_d;

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] sel_waddr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  do_write;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1_valid, wb0_valid}),
    .gnt (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // Bit 0 of the scoreboard is never set, so x0 is always ready and never busy.
  assign iss_ready = ~pending_q[iss_rd];
  assign chk_busy  = pending_q[chk_raddr1] | pending_q[chk_raddr2];

  always_comb begin
    sel_waddr = gnt[1] ? wb1_waddr : wb0_waddr;
    sel_wdata = gnt[1] ? wb1_wdata : wb0_wdata;
    do_write  = (|gnt) && (sel_waddr != '0);

    rf_wen_d   = do_write;
    rf_waddr_d = do_write ? sel_waddr : rf_waddr_q;
    rf_wdata_d = do_write ? sel_wdata : rf_wdata_q;
  end

  // Clear from the committing write is applied first so a same-edge issue wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter with hand-written sequences
// for reset-after-grant and back-to-back round-robin conflicts.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_ready;
  logic [AW-1:0] chk_raddr1;
  logic [AW-1:0] chk_raddr2;
  logic          chk_busy;
  logic          wb0_valid;
  logic [AW-1:0] wb0_waddr;
  logic [DW-1:0] wb0_wdata;
  logic          wb0_ready;
  logic          wb1_valid;
  logic [AW-1:0] wb1_waddr;
  logic [DW-1:0] wb1_wdata;
  logic          wb1_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks;
  int failures;

  typedef struct {
    logic          iv;
    logic [AW-1:0] ird;
    logic [AW-1:0] c1;
    logic [AW-1:0] c2;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_ir;
    logic          e_busy;
    logic          e_g0;
    logic          e_g1;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  rf_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .chk_raddr1 (chk_raddr1),
    .chk_raddr2 (chk_raddr2),
    .chk_busy   (chk_busy),
    .wb0_valid  (wb0_valid),
    .wb0_waddr  (wb0_waddr),
    .wb0_wdata  (wb0_wdata),
    .wb0_ready  (wb0_ready),
    .wb1_valid  (wb1_valid),
    .wb1_waddr  (wb1_waddr),
    .wb1_wdata  (wb1_wdata),
    .wb1_ready  (wb1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    iss_valid  = v.iv;
    iss_rd     = v.ird;
    chk_raddr1 = v.c1;
    chk_raddr2 = v.c2;
    wb0_valid  = v.v0;
    wb0_waddr  = v.a0;
    wb0_wdata  = v.d0;
    wb1_valid  = v.v1;
    wb1_waddr  = v.a1;
    wb1_wdata  = v.d1;
  endtask

  task automatic addVec(input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] c1,
                        input logic [AW-1:0] c2, input logic v0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic v1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input logic e_ir, input logic e_busy,
                        input logic e_g0, input logic e_g1, input logic e_wen,
                        input logic [AW-1:0] e_waddr, input logic [DW-1:0] e_wdata);
    vec_t v;
    v.iv = iv; v.ird = ird; v.c1 = c1; v.c2 = c2;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.e_ir = e_ir; v.e_busy = e_busy; v.e_g0 = e_g0; v.e_g1 = e_g1;
    v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    vecs.push_back(v);
  endtask

  task automatic clearInputs();
    iss_valid  = 1'b0;
    iss_rd     = '0;
    chk_raddr1 = '0;
    chk_raddr2 = '0;
    wb0_valid  = 1'b0;
    wb0_waddr  = '0;
    wb0_wdata  = '0;
    wb1_valid  = 1'b0;
    wb1_waddr  = '0;
    wb1_wdata  = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //     iv ird c1 c2  v0 a0 d0            v1 a1 d1          ir bsy g0 g1 wen waddr wdata
    addVec(1, 5,  5, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 0,  0,  32'h0);
    addVec(0, 5,  5, 0,  1, 5, 32'hDEADBEEF, 0, 0, 32'h0,      0, 1,  1, 0, 0,  0,  32'h0);
    addVec(0, 5,  5, 0,  0, 0, 32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 1,  5,  32'hDEADBEEF);
    addVec(0, 5,  5, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 0,  5,  32'hDEADBEEF);
    addVec(0, 0,  3, 4,  1, 3, 32'h33,       1, 4, 32'h44,     1, 0,  0, 1, 0,  5,  32'hDEADBEEF);
    addVec(0, 0,  3, 4,  1, 3, 32'h33,       1, 6, 32'h66,     1, 0,  1, 0, 1,  4,  32'h44);
    addVec(0, 0,  3, 4,  1, 8, 32'h88,       1, 6, 32'h66,     1, 0,  0, 1, 1,  3,  32'h33);
    addVec(0, 0,  0, 0,  0, 0, 32'h0,        1, 0, 32'h1234,   1, 0,  0, 1, 1,  6,  32'h66);
    addVec(0, 0,  0, 0,  0, 0, 32'h0,        1, 10, 32'hAA,    1, 0,  0, 1, 0,  6,  32'h66);
    addVec(0, 0,  0, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 1,  10, 32'hAA);
    addVec(1, 7,  0, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 0,  10, 32'hAA);
    addVec(1, 7,  7, 0,  0, 0, 32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0,  10, 32'hAA);
    addVec(1, 7,  7, 0,  1, 7, 32'h77,       0, 0, 32'h0,      0, 1,  1, 0, 0,  10, 32'hAA);
    addVec(1, 7,  7, 0,  0, 0, 32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 1,  7,  32'h77);
    addVec(0, 7,  7, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 0,  7,  32'h77);
    addVec(0, 0,  9, 0,  1, 9, 32'h99,       0, 0, 32'h0,      1, 0,  1, 0, 0,  7,  32'h77);
    addVec(1, 9,  9, 0,  0, 0, 32'h0,        0, 0, 32'h0,      1, 0,  0, 0, 1,  9,  32'h99);
    addVec(0, 9,  0, 9,  0, 0, 32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0,  9,  32'h99);

    // Reset state, with a conflicting request to observe the reset pointer.
    clearInputs();
    rst = 1'b0;
    @(negedge clk);
    wb0_valid = 1'b1; wb0_waddr = 5'd1;
    wb1_valid = 1'b1; wb1_waddr = 5'd2;
    iss_rd = 5'd5; chk_raddr1 = 5'd5; chk_raddr2 = 5'd9;
    #1;
    checkOutput("rst_iss_ready", iss_ready, 1);
    checkOutput("rst_chk_busy", chk_busy, 0);
    checkOutput("rst_wb0_ready", wb0_ready, 1);
    checkOutput("rst_wb1_ready", wb1_ready, 0);
    checkOutput("rst_rf_wen", rf_wen, 0);
    checkOutput("rst_rf_waddr", rf_waddr, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    @(negedge clk);
    clearInputs();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_iss_ready", i), iss_ready, vecs[i].e_ir);
      checkOutput($sformatf("v%0d_chk_busy", i), chk_busy, vecs[i].e_busy);
      checkOutput($sformatf("v%0d_wb0_ready", i), wb0_ready, vecs[i].e_g0);
      checkOutput($sformatf("v%0d_wb1_ready", i), wb1_ready, vecs[i].e_g1);
      checkOutput($sformatf("v%0d_rf_wen", i), rf_wen, vecs[i].e_wen);
      checkOutput($sformatf("v%0d_rf_waddr", i), rf_waddr, vecs[i].e_waddr);
      checkOutput($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
    end

    // Grant to wb1 (pointer favours 1 here), then reset in the following cycle.
    @(negedge clk);
    clearInputs();
    wb0_valid = 1'b1; wb0_waddr = 5'd11; wb0_wdata = 32'hB0;
    wb1_valid = 1'b1; wb1_waddr = 5'd12; wb1_wdata = 32'hC0;
    iss_rd = 5'd9; chk_raddr1 = 5'd9;
    #1;
    checkOutput("pre_rst_wb0_ready", wb0_ready, 0);
    checkOutput("pre_rst_wb1_ready", wb1_ready, 1);
    checkOutput("pre_rst_chk_busy", chk_busy, 1);
    @(negedge clk);
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    #1;
    checkOutput("pre_rst_rf_wen", rf_wen, 1);
    checkOutput("pre_rst_rf_waddr", rf_waddr, 12);
    checkOutput("pre_rst_rf_wdata", rf_wdata, 32'hC0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_rf_wen", rf_wen, 0);
    checkOutput("mid_rst_rf_waddr", rf_waddr, 0);
    checkOutput("mid_rst_rf_wdata", rf_wdata, 0);
    checkOutput("mid_rst_chk_busy", chk_busy, 0);
    checkOutput("mid_rst_iss_ready", iss_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post_rst%0d_rf_wen", k), rf_wen, 0);
      checkOutput($sformatf("post_rst%0d_chk_busy", k), chk_busy, 0);
    end

    // Three back-to-back conflicts from a fresh pointer: grants 0,1,0.
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      @(negedge clk);
      wb0_valid = (k < 3);
      wb0_waddr = AW'(20 + k);
      wb0_wdata = DW'(32'h100 + k);
      wb1_valid = (k < 3);
      wb1_waddr = AW'(24 + k);
      wb1_wdata = DW'(32'h200 + k);
      #1;
      checkOutput($sformatf("rr%0d_wb0_ready", k), wb0_ready, (k == 0 || k == 2) ? 1 : 0);
      checkOutput($sformatf("rr%0d_wb1_ready", k), wb1_ready, (k == 1) ? 1 : 0);
      if (k == 0) begin
        checkOutput("rr0_rf_wen", rf_wen, 0);
      end else begin
        exp_addr = (k - 1 == 1) ? AW'(24 + k - 1) : AW'(20 + k - 1);
        exp_data = (k - 1 == 1) ? DW'(32'h200 + k - 1) : DW'(32'h100 + k - 1);
        checkOutput($sformatf("rr%0d_rf_wen", k), rf_wen, 1);
        checkOutput($sformatf("rr%0d_rf_waddr", k), rf_waddr, exp_addr);
        checkOutput($sformatf("rr%0d_rf_wdata", k), rf_wdata, exp_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
